// File: rtl/riscv_pkg.sv
// Encodings shared by decode, MEM and writeback: result-select codes and load funct3 values.
package riscv_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_align.sv
// Load formatter: shifts the raw memory word down to the addressed byte/half and extends it.
// Also flags misaligned halves/words and funct3 codes that are not loads.
module load_align
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] raw_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o,
  output logic            fault_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = raw_i >> {addr_lo_i, 3'b000};

  always_comb begin
    data_o  = '0;
    fault_o = 1'b0;
    case (funct3_i)
      F3_LB:  data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      F3_LH: begin
        data_o  = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
        fault_o = addr_lo_i[0];
      end
      F3_LHU: begin
        data_o  = {{(XLEN-16){1'b0}}, shifted[15:0]};
        fault_o = addr_lo_i[0];
      end
      F3_LW: begin
        data_o  = shifted;
        fault_o = (addr_lo_i != 2'b00);
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and result mux; drives the register-file write port,
// raises a one-cycle load_fault pulse and counts retired instructions.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RA_W  = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_reg_write,
  input  logic [RA_W-1:0]  in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu_result,
  input  logic [XLEN-1:0]  in_load_data,
  input  logic [2:0]       in_funct3,
  input  logic [1:0]       in_addr_lo,
  input  logic [XLEN-1:0]  in_pc_plus4,
  input  logic             flush,
  input  logic             hold,
  output logic             RegWrite,
  output logic [RA_W-1:0]  Rd,
  output logic [XLEN-1:0]  Write_data,
  output logic             load_fault,
  output logic [CNT_W-1:0] instret
);

  logic             wb_valid_q;
  logic             reg_write_q;
  logic [RA_W-1:0]  rd_q;
  wb_sel_e          wb_sel_q;
  logic [XLEN-1:0]  alu_q;
  logic [XLEN-1:0]  load_q;
  logic [2:0]       funct3_q;
  logic [1:0]       addr_lo_q;
  logic [XLEN-1:0]  pc4_q;
  logic             load_fault_q, load_fault_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic [XLEN-1:0]  ld_data;
  logic             ld_fault;
  logic             fault;
  logic             capture;
  logic             retire;

  assign in_ready = ~hold;
  assign capture  = in_valid & ~hold & ~flush;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_valid_q  <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      wb_sel_q    <= WB_ALU;
      alu_q       <= '0;
      load_q      <= '0;
      funct3_q    <= '0;
      addr_lo_q   <= '0;
      pc4_q       <= '0;
    end else if (flush) begin
      wb_valid_q  <= 1'b0;
    end else if (capture) begin
      wb_valid_q  <= 1'b1;
      reg_write_q <= in_reg_write;
      rd_q        <= in_rd;
      wb_sel_q    <= wb_sel_e'(in_wb_sel);
      alu_q       <= in_alu_result;
      load_q      <= in_load_data;
      funct3_q    <= in_funct3;
      addr_lo_q   <= in_addr_lo;
      pc4_q       <= in_pc_plus4;
    end else if (!hold) begin
      wb_valid_q  <= 1'b0;
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .raw_i     (load_q),
    .addr_lo_i (addr_lo_q),
    .funct3_i  (funct3_q),
    .data_o    (ld_data),
    .fault_o   (ld_fault)
  );

  assign fault = wb_valid_q & (wb_sel_q == WB_LOAD) & ld_fault;

  always_comb begin
    Write_data = '0;
    case (wb_sel_q)
      WB_ALU:  Write_data = alu_q;
      WB_LOAD: Write_data = ld_data;
      WB_PC4:  Write_data = pc4_q;
      default: Write_data = '0;
    endcase
  end

  assign Rd       = rd_q;
  assign RegWrite = wb_valid_q & ~hold & reg_write_q & (rd_q != '0) & ~fault
                    & (wb_sel_q != WB_RSVD);

  // A flushed cycle still writes the live entry but does not count it as retired.
  assign retire       = wb_valid_q & ~hold & ~fault & ~flush;
  assign instret_d    = retire ? instret_q + CNT_W'(1) : instret_q;
  assign load_fault_d = wb_valid_q & ~hold & fault;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      load_fault_q <= 1'b0;
      instret_q    <= '0;
    end else begin
      load_fault_q <= load_fault_d;
      instret_q    <= instret_d;
    end
  end

  assign load_fault = load_fault_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: ALU/load/PC+4 results, faults, x0, hold, flush, reset.
module tb_writeback_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu_result;
  logic [31:0] in_load_data;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [31:0] in_pc_plus4;
  logic        flush;
  logic        hold;
  logic        RegWrite;
  logic [4:0]  Rd;
  logic [31:0] Write_data;
  logic        load_fault;
  logic [63:0] instret;

  int          errors;
  int          checks;
  logic [63:0] exp_cnt;

  writeback_stage #(.XLEN(32), .RA_W(5), .CNT_W(64)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_wb_sel     (in_wb_sel),
    .in_alu_result (in_alu_result),
    .in_load_data  (in_load_data),
    .in_funct3     (in_funct3),
    .in_addr_lo    (in_addr_lo),
    .in_pc_plus4   (in_pc_plus4),
    .flush         (flush),
    .hold          (hold),
    .RegWrite      (RegWrite),
    .Rd            (Rd),
    .Write_data    (Write_data),
    .load_fault    (load_fault),
    .instret       (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one entry for exactly one capture edge; returns 1 time unit after that edge.
  task automatic send(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                      input logic [31:0] alu, input logic [31:0] ld, input logic [2:0] f3,
                      input logic [1:0] alo, input logic [31:0] pc4);
    @(negedge clk);
    in_valid      = 1'b1;
    in_reg_write  = rw;
    in_rd         = rd;
    in_wb_sel     = sel;
    in_alu_result = alu;
    in_load_data  = ld;
    in_funct3     = f3;
    in_addr_lo    = alo;
    in_pc_plus4   = pc4;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got=%b exp=0", RegWrite); end
    checks++; if (Rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", Rd); end
    checks++; if (Write_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got=%h exp=00000000", Write_data); end
    checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
    checks++; if (load_fault !== 1'b0) begin errors++; $display("FAIL reset_fault got=%b exp=0", load_fault); end
    @(negedge clk);
    reset = 1'b1;
    exp_cnt = 64'd0;
  endtask

  task automatic test_alu();
    send(1'b1, 5'd5, 2'b00, 32'hDEADBEEF, 32'h0, 3'b010, 2'd0, 32'h0);
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL alu_regwrite got=%b exp=1", RegWrite); end
    checks++; if (Rd !== 5'd5) begin errors++; $display("FAIL alu_rd got=%0d exp=5", Rd); end
    checks++; if (Write_data !== 32'hDEADBEEF) begin errors++; $display("FAIL alu_wdata got=%h exp=deadbeef", Write_data); end
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL alu_instret_before got=%0d exp=%0d", instret, exp_cnt); end
    next_cycle();
    exp_cnt++;
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL alu_instret_after got=%0d exp=%0d", instret, exp_cnt); end
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL alu_single_write got=%b exp=0", RegWrite); end
  endtask

  task automatic test_pc4();
    send(1'b1, 5'd1, 2'b10, 32'h11111111, 32'h0, 3'b000, 2'd0, 32'h00000104);
    checks++; if (RegWrite !== 1'b1 || Write_data !== 32'h00000104) begin
      errors++; $display("FAIL pc4 got we=%b data=%h exp we=1 data=00000104", RegWrite, Write_data); end
    next_cycle();
    exp_cnt++;
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [4];
    logic [1:0]  alo [4];
    logic [31:0] exp [4];
    f3[0] = 3'b000; alo[0] = 2'd2; exp[0] = 32'hFFFFFFF4;
    f3[1] = 3'b100; alo[1] = 2'd2; exp[1] = 32'h000000F4;
    f3[2] = 3'b001; alo[2] = 2'd2; exp[2] = 32'h000012F4;
    f3[3] = 3'b010; alo[3] = 2'd0; exp[3] = 32'h12F45678;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, 5'(10 + i), 2'b01, 32'h0, 32'h12F45678, f3[i], alo[i], 32'h0);
      checks++; if (Write_data !== exp[i] || RegWrite !== 1'b1 || Rd !== 5'(10 + i)) begin
        errors++; $display("FAIL load_%0d got we=%b rd=%0d data=%h exp we=1 rd=%0d data=%h",
                           i, RegWrite, Rd, Write_data, 10 + i, exp[i]); end
      next_cycle();
      exp_cnt++;
      checks++; if (instret !== exp_cnt || load_fault !== 1'b0) begin
        errors++; $display("FAIL load_%0d_retire got cnt=%0d fault=%b exp cnt=%0d fault=0",
                           i, instret, load_fault, exp_cnt); end
    end
  endtask

  task automatic test_faults();
    logic [2:0] f3  [2];
    logic [1:0] alo [2];
    f3[0] = 3'b010; alo[0] = 2'd1;
    f3[1] = 3'b011; alo[1] = 2'd0;
    for (int i = 0; i < 2; i++) begin
      send(1'b1, 5'd7, 2'b01, 32'h0, 32'h12F45678, f3[i], alo[i], 32'h0);
      checks++; if (RegWrite !== 1'b0 || load_fault !== 1'b0) begin
        errors++; $display("FAIL fault_%0d_cycle got we=%b fault=%b exp we=0 fault=0", i, RegWrite, load_fault); end
      next_cycle();
      checks++; if (load_fault !== 1'b1 || instret !== exp_cnt) begin
        errors++; $display("FAIL fault_%0d_pulse got fault=%b cnt=%0d exp fault=1 cnt=%0d", i, load_fault, instret, exp_cnt); end
      next_cycle();
      checks++; if (load_fault !== 1'b0) begin
        errors++; $display("FAIL fault_%0d_clear got fault=%b exp=0", i, load_fault); end
    end
  endtask

  task automatic test_x0_reserved();
    send(1'b1, 5'd0, 2'b00, 32'hCAFEF00D, 32'h0, 3'b000, 2'd0, 32'h0);
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL x0_regwrite got=%b exp=0", RegWrite); end
    next_cycle();
    exp_cnt++;
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL x0_instret got=%0d exp=%0d", instret, exp_cnt); end
    send(1'b1, 5'd3, 2'b11, 32'hCAFEF00D, 32'h0, 3'b000, 2'd0, 32'h12345678);
    checks++; if (RegWrite !== 1'b0 || Write_data !== 32'h0) begin
      errors++; $display("FAIL rsvd_cycle got we=%b data=%h exp we=0 data=00000000", RegWrite, Write_data); end
    next_cycle();
    exp_cnt++;
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL rsvd_instret got=%0d exp=%0d", instret, exp_cnt); end
  endtask

  task automatic test_hold();
    send(1'b1, 5'd9, 2'b00, 32'h00001234, 32'h0, 3'b000, 2'd0, 32'h0);
    hold     = 1'b1;
    in_valid = 1'b1;
    in_rd    = 5'd20;
    #1;
    checks++; if (in_ready !== 1'b0 || RegWrite !== 1'b0) begin
      errors++; $display("FAIL hold_enter got ready=%b we=%b exp ready=0 we=0", in_ready, RegWrite); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      checks++; if (in_ready !== 1'b0 || RegWrite !== 1'b0 || instret !== exp_cnt || Rd !== 5'd9) begin
        errors++; $display("FAIL hold_%0d got ready=%b we=%b rd=%0d cnt=%0d exp ready=0 we=0 rd=9 cnt=%0d",
                           i, in_ready, RegWrite, Rd, instret, exp_cnt); end
    end
    in_valid = 1'b0;
    hold     = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b1 || Rd !== 5'd9 || Write_data !== 32'h00001234) begin
      errors++; $display("FAIL hold_release got we=%b rd=%0d data=%h exp we=1 rd=9 data=00001234",
                         RegWrite, Rd, Write_data); end
    next_cycle();
    exp_cnt++;
    checks++; if (RegWrite !== 1'b0 || instret !== exp_cnt) begin
      errors++; $display("FAIL hold_once got we=%b cnt=%0d exp we=0 cnt=%0d", RegWrite, instret, exp_cnt); end
  endtask

  task automatic test_flush();
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_reg_write = 1'b1; in_rd = 5'd4;
    in_wb_sel = 2'b00; in_alu_result = 32'h000000AA;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++; if (RegWrite !== 1'b0) begin errors++; $display("FAIL flush_incoming got we=%b exp=0", RegWrite); end
    next_cycle();
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL flush_incoming_cnt got=%0d exp=%0d", instret, exp_cnt); end
    // Live entry plus flush: entry still writes, the next capture is killed.
    send(1'b1, 5'd6, 2'b00, 32'h00000066, 32'h0, 3'b000, 2'd0, 32'h0);
    flush = 1'b1; in_valid = 1'b1; in_rd = 5'd8;
    #1;
    checks++; if (RegWrite !== 1'b1 || Rd !== 5'd6) begin
      errors++; $display("FAIL flush_live got we=%b rd=%0d exp we=1 rd=6", RegWrite, Rd); end
    next_cycle();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (RegWrite !== 1'b0 || instret !== exp_cnt) begin
      errors++; $display("FAIL flush_kill got we=%b cnt=%0d exp we=0 cnt=%0d", RegWrite, instret, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b0; in_reg_write = 1'b1; in_rd = 5'd1;
    in_wb_sel = 2'b00; in_alu_result = 32'd11;
    @(posedge clk);
    #1;
    checks++; if (Rd !== 5'd1 || Write_data !== 32'd11 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL b2b_first got we=%b rd=%0d data=%h exp we=1 rd=1 data=0000000b", RegWrite, Rd, Write_data); end
    @(negedge clk);
    in_rd = 5'd2; in_alu_result = 32'd22;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++; if (Rd !== 5'd2 || Write_data !== 32'd22 || RegWrite !== 1'b1) begin
      errors++; $display("FAIL b2b_second got we=%b rd=%0d data=%h exp we=1 rd=2 data=00000016", RegWrite, Rd, Write_data); end
    next_cycle();
    exp_cnt = exp_cnt + 64'd2;
    checks++; if (instret !== exp_cnt) begin errors++; $display("FAIL b2b_instret got=%0d exp=%0d", instret, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 5'd7, 2'b00, 32'h0BADF00D, 32'h0, 3'b000, 2'd0, 32'h0);
    checks++; if (RegWrite !== 1'b1) begin errors++; $display("FAIL midreset_pre got we=%b exp=1", RegWrite); end
    reset = 1'b0;
    #1;
    checks++; if (RegWrite !== 1'b0 || Rd !== 5'd0 || Write_data !== 32'h0) begin
      errors++; $display("FAIL midreset_outputs got we=%b rd=%0d data=%h exp we=0 rd=0 data=00000000", RegWrite, Rd, Write_data); end
    checks++; if (instret !== 64'd0 || load_fault !== 1'b0) begin
      errors++; $display("FAIL midreset_state got cnt=%0d fault=%b exp cnt=0 fault=0", instret, load_fault); end
    next_cycle();
    checks++; if (RegWrite !== 1'b0 || instret !== 64'd0) begin
      errors++; $display("FAIL midreset_held got we=%b cnt=%0d exp we=0 cnt=0", RegWrite, instret); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    errors = 0; checks = 0; exp_cnt = 64'd0;
    reset = 1'b0; in_valid = 1'b0; in_reg_write = 1'b0; in_rd = '0; in_wb_sel = '0;
    in_alu_result = '0; in_load_data = '0; in_funct3 = '0; in_addr_lo = '0;
    in_pc_plus4 = '0; flush = 1'b0; hold = 1'b0;
    test_reset();
    test_alu();
    test_pc4();
    test_loads();
    test_faults();
    test_x0_reserved();
    test_hold();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
